// File: rtl/uart_pkg.sv
// uart_pkg: shared encodings, oversampling constants and FSM states for uart_ctrl
package uart_pkg;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 7;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO with registered full/empty
module uart_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count, count_nxt;
    logic                  do_wr, do_rd;
    assign do_wr     = wr && !full;
    assign do_rd     = rd && !empty;
    assign count_nxt = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    // Head is masked while empty so the read port shows zero out of reset.
    assign rd_data   = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= do_wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_rd ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count_nxt;
            full   <= count_nxt == (AW+1)'(FIFO_DEPTH);
            empty  <= count_nxt == '0;
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: buffered 16x-oversampled UART with programmable baud, parity and stop bits
module uart_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DVSR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DVSR_WIDTH-1:0] dvsr,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    input  logic                  rx,
    output logic                  tx,
    input  logic                  tx_wr,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_full,
    output logic                  tx_busy,
    input  logic                  rx_rd,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_empty,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  err_clr
);
    import uart_pkg::*;
    logic                  tick, tx_empty_q, tx_pop, rx_push, rx_full_q;
    logic [DVSR_WIDTH-1:0] bcnt;
    logic [DATA_WIDTH-1:0] tx_head;
    tx_state_t             tx_state, tx_state_n;
    logic [4:0]            tx_tcnt, tx_tcnt_n;
    logic [3:0]            tx_bits, tx_bits_n;
    logic [DATA_WIDTH-1:0] tx_sh, tx_sh_n;
    logic                  tx_pen, tx_pen_n, tx_pbit, tx_pbit_n, tx_two, tx_two_n, tx_n, tx_bit_end;
    logic                  rx_s1, rx_s2, rx_pen, rx_sample, rx_perr, rx_perr_n, set_ferr;
    rx_state_t             rx_state, rx_state_n;
    logic [3:0]            rx_tcnt, rx_tcnt_n, rx_bits, rx_bits_n;
    logic [DATA_WIDTH-1:0] rx_sh, rx_sh_n;

    uart_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .wr(tx_wr), .wr_data(tx_data), .rd(tx_pop),
        .rd_data(tx_head), .full(tx_full), .empty(tx_empty_q)
    );
    uart_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .wr(rx_push), .wr_data(rx_sh), .rd(rx_rd),
        .rd_data(rx_data), .full(rx_full_q), .empty(rx_empty)
    );

    // dvsr of 0 behaves as 1; a count stranded above a lowered dvsr restarts at 0.
    assign tick       = (dvsr == '0) || (bcnt == dvsr - DVSR_WIDTH'(1));
    assign tx_busy    = (tx_state != TX_IDLE) || !tx_empty_q;
    assign tx_bit_end = tick && tx_tcnt == ((tx_state == TX_STOP && tx_two) ? 5'(2*OVERSAMPLE-1) : 5'(OVERSAMPLE-1));
    assign rx_pen     = parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
    assign rx_sample  = tick && rx_tcnt == (rx_state == RX_START ? 4'(START_MID-1) : 4'(OVERSAMPLE-1));

    always_comb begin
        tx_state_n = tx_state;
        tx_tcnt_n  = tick ? (tx_bit_end ? '0 : tx_tcnt + 5'd1) : tx_tcnt;
        tx_bits_n  = tx_bits;
        tx_sh_n    = tx_sh;
        tx_pen_n   = tx_pen;
        tx_pbit_n  = tx_pbit;
        tx_two_n   = tx_two;
        tx_pop     = 1'b0;
        case (tx_state)
            TX_IDLE:   tx_pop = !tx_empty_q;
            TX_START:  if (tx_bit_end) tx_state_n = TX_DATA;
            TX_DATA:   if (tx_bit_end) begin
                tx_sh_n   = tx_sh >> 1;
                tx_bits_n = tx_bits + 4'd1;
                if (tx_bits == 4'(DATA_WIDTH-1)) tx_state_n = tx_pen ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: if (tx_bit_end) tx_state_n = TX_STOP;
            TX_STOP:   if (tx_bit_end) begin
                tx_state_n = TX_IDLE;
                tx_pop     = !tx_empty_q;
            end
            default:   tx_state_n = TX_IDLE;
        endcase
        // Loading straight from STOP keeps queued frames contiguous.
        if (tx_pop) begin
            tx_state_n = TX_START;
            tx_tcnt_n  = '0;
            tx_bits_n  = '0;
            tx_sh_n    = tx_head;
            tx_pen_n   = parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
            tx_pbit_n  = ^tx_head ^ (parity_mode == PAR_ODD);
            tx_two_n   = two_stop;
        end
        tx_n = tx_state_n == TX_START ? 1'b0 : tx_state_n == TX_DATA ? tx_sh_n[0] :
               tx_state_n == TX_PARITY ? tx_pbit_n : 1'b1;
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n  = rx_sample ? '0 : rx_tcnt + 4'(tick);
        rx_bits_n  = rx_bits;
        rx_sh_n    = rx_sh;
        rx_perr_n  = rx_perr;
        rx_push    = 1'b0;
        set_ferr   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_tcnt_n = '0;
                rx_bits_n = '0;
                rx_perr_n = 1'b0;
                if (!rx_s2) rx_state_n = RX_START;
            end
            RX_START:  if (rx_sample) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample) begin
                rx_sh_n   = {rx_s2, rx_sh[DATA_WIDTH-1:1]};
                rx_bits_n = rx_bits + 4'd1;
                if (rx_bits == 4'(DATA_WIDTH-1)) rx_state_n = rx_pen ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_sample) begin
                rx_perr_n  = rx_s2 ^ (^rx_sh) ^ (parity_mode == PAR_ODD);
                rx_state_n = RX_STOP;
            end
            RX_STOP:   if (rx_sample) begin
                rx_push    = 1'b1;
                set_ferr   = !rx_s2;
                rx_state_n = RX_IDLE;
            end
            default:   rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt       <= '0;
            tx_state   <= TX_IDLE;
            tx_tcnt    <= '0;
            tx_bits    <= '0;
            tx_sh      <= '0;
            tx_pen     <= 1'b0;
            tx_pbit    <= 1'b0;
            tx_two     <= 1'b0;
            tx         <= 1'b1;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_tcnt    <= '0;
            rx_bits    <= '0;
            rx_sh      <= '0;
            rx_perr    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            bcnt       <= (tick || bcnt >= dvsr) ? '0 : bcnt + DVSR_WIDTH'(1);
            tx_state   <= tx_state_n;
            tx_tcnt    <= tx_tcnt_n;
            tx_bits    <= tx_bits_n;
            tx_sh      <= tx_sh_n;
            tx_pen     <= tx_pen_n;
            tx_pbit    <= tx_pbit_n;
            tx_two     <= tx_two_n;
            tx         <= tx_n;
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_state   <= rx_state_n;
            rx_tcnt    <= rx_tcnt_n;
            rx_bits    <= rx_bits_n;
            rx_sh      <= rx_sh_n;
            rx_perr    <= rx_perr_n;
            parity_err <= (parity_err && !err_clr) || (rx_push && rx_perr);
            frame_err  <= (frame_err && !err_clr) || set_ferr;
            overrun    <= (overrun && !err_clr) || (rx_push && rx_full_q);
        end
    end
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed scenarios for uart_ctrl with hand-computed frames and flags
module tb_uart_ctrl;
    logic        clk = 0, reset_n = 0, two_stop = 0, tx_wr = 0, rx_rd = 0, err_clr = 0;
    logic        loop = 0, rx_drv = 1, rx_line, tx, tx_full, tx_busy, rx_empty;
    logic        parity_err, frame_err, overrun;
    logic [15:0] dvsr = 16'd4;
    logic [1:0]  parity_mode = 2'b00;
    logic [7:0]  tx_data = 0, rx_data;
    int          errors = 0, checks = 0, cyc = 0;

    assign rx_line = loop ? tx : rx_drv;

    uart_ctrl dut (
        .clk(clk), .reset_n(reset_n), .dvsr(dvsr), .parity_mode(parity_mode), .two_stop(two_stop),
        .rx(rx_line), .tx(tx), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .tx_busy(tx_busy),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_word(input logic [7:0] w);
        tx_data = w;
        tx_wr   = 1;
        step(1);
        tx_wr   = 0;
    endtask

    task automatic pop();
        rx_rd = 1;
        step(1);
        rx_rd = 0;
    endtask

    task automatic clear_errs();
        err_clr = 1;
        step(1);
        err_clr = 0;
    endtask

    task automatic wait_rx(output bit ok);
        int n = 0;
        while (rx_empty && n < 3000) begin
            step(1);
            n++;
        end
        ok = !rx_empty;
    endtask

    // Drives one frame on rx at 64 cycles per bit (dvsr=4); a low stop bit is cut short.
    task automatic send_frame(input logic [8:0] bits, input int n, input logic stop_bit);
        rx_drv = 0;
        step(64);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            step(64);
        end
        rx_drv = stop_bit;
        step(40);
        rx_drv = 1;
        step(100);
    endtask

    task automatic test_reset();
        reset_n = 0;
        step(2);
        reset_n = 1;
        step(1);
        checks += 7;
        if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        if (tx_full !== 1'b0)  begin errors++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
        if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        if ({parity_err, frame_err, overrun} !== 3'b000)
            begin errors++; $display("FAIL reset_flags: got %b want 000", {parity_err, frame_err, overrun}); end
        step(5);
        if (tx !== 1'b1)       begin errors++; $display("FAIL reset_idle_tx: got %b want 1", tx); end
    endtask

    task automatic test_8n1();
        logic [8:0] exp = {1'b1, 8'hA5};
        int s = 0;
        bit ok;
        dvsr = 4; parity_mode = 2'b00; two_stop = 0; loop = 1;
        write_word(8'hA5);
        checks += 3;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", tx_busy); end
        if (tx !== 1'b1)      begin errors++; $display("FAIL tx_before_start: got %b want 1", tx); end
        step(1);
        if (tx !== 1'b0)      begin errors++; $display("FAIL tx_latency: got %b want 0", tx); end
        while (tx === 1'b0 && s < 100) begin
            step(1);
            s++;
        end
        checks++;
        if (s < 61 || s > 64) begin errors++; $display("FAIL start_len: got %0d want 61..64", s); end
        for (int i = 0; i < 9; i++) begin
            step(i == 0 ? 32 : 64);
            checks++;
            if (tx !== exp[i]) begin errors++; $display("FAIL a5_bit%0d: got %b want %b", i, tx, exp[i]); end
        end
        step(31);
        checks += 2;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL busy_last_stop: got %b want 1", tx_busy); end
        step(1);
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", tx_busy); end
        wait_rx(ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL a5_rx_timeout: got empty want data"); end
        if (rx_data !== 8'hA5) begin errors++; $display("FAIL a5_loopback: got %h want a5", rx_data); end
        if ({parity_err, frame_err, overrun} !== 3'b000)
            begin errors++; $display("FAIL a5_flags: got %b want 000", {parity_err, frame_err, overrun}); end
        pop();
        checks++;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL a5_pop_empty: got %b want 1", rx_empty); end
    endtask

    task automatic test_parity();
        logic [10:0] exp = {1'b1, 1'b1, 1'b1, 8'h07};
        int s = 0;
        bit ok;
        dvsr = 4; parity_mode = 2'b01; two_stop = 1; loop = 1;
        write_word(8'h07);
        step(1);
        while (tx === 1'b0 && s < 100) begin
            step(1);
            s++;
        end
        for (int i = 0; i < 11; i++) begin
            step(i == 0 ? 32 : 64);
            checks++;
            if (tx !== exp[i]) begin errors++; $display("FAIL par_bit%0d: got %b want %b", i, tx, exp[i]); end
        end
        step(31);
        checks += 2;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL two_stop_busy: got %b want 1", tx_busy); end
        step(1);
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL two_stop_fall: got %b want 0", tx_busy); end
        wait_rx(ok);
        checks += 2;
        if (rx_data !== 8'h07 || !ok) begin errors++; $display("FAIL par_loopback: got %h want 07", rx_data); end
        if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b want 0", parity_err); end
        pop();
        loop = 0; rx_drv = 1;
        step(10);
        send_frame({1'b0, 8'h07}, 9, 1'b1);
        wait_rx(ok);
        checks += 3;
        if (parity_err !== 1'b1) begin errors++; $display("FAIL par_err_set: got %b want 1", parity_err); end
        if (rx_data !== 8'h07 || !ok) begin errors++; $display("FAIL par_err_word: got %h want 07", rx_data); end
        if (frame_err !== 1'b0) begin errors++; $display("FAIL par_err_frame: got %b want 0", frame_err); end
        pop();
        clear_errs();
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL par_err_clr: got %b want 0", parity_err); end
    endtask

    task automatic test_frame_glitch();
        bit ok;
        parity_mode = 2'b00; two_stop = 0; loop = 0; rx_drv = 1;
        step(10);
        send_frame({1'b0, 8'h3C}, 8, 1'b0);
        wait_rx(ok);
        checks += 3;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_set: got %b want 1", frame_err); end
        if (rx_data !== 8'h3C || !ok) begin errors++; $display("FAIL frame_word: got %h want 3c", rx_data); end
        if (parity_err !== 1'b0) begin errors++; $display("FAIL frame_par: got %b want 0", parity_err); end
        pop();
        checks++;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL frame_single_push: got %b want 1", rx_empty); end
        clear_errs();
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_clr: got %b want 0", frame_err); end
        rx_drv = 0;
        step(12);
        rx_drv = 1;
        step(300);
        checks += 2;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL glitch_push: got %b want 1", rx_empty); end
        if ({parity_err, frame_err, overrun} !== 3'b000)
            begin errors++; $display("FAIL glitch_flags: got %b want 000", {parity_err, frame_err, overrun}); end
    endtask

    task automatic test_overrun();
        int n = 0;
        dvsr = 4; parity_mode = 2'b00; two_stop = 0; loop = 1;
        for (int i = 0; i < 17; i++) write_word(8'(8'h40 + i));
        while (tx_busy && n < 20000) begin
            step(1);
            n++;
        end
        step(100);
        checks += 2;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL ovr_tx_timeout: got busy %b want 0", tx_busy); end
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (rx_empty !== 1'b0 || rx_data !== 8'(8'h40 + i))
                begin errors++; $display("FAIL ovr_word%0d: got %h empty %b want %h", i, rx_data, rx_empty, 8'(8'h40 + i)); end
            pop();
        end
        checks++;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovr_drop17: got empty %b want 1", rx_empty); end
        clear_errs();
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", overrun); end
    endtask

    task automatic test_back_to_back();
        int starts[17];
        int t0 = -1, n, lows = 0;
        logic [7:0] w;
        dvsr = 4; parity_mode = 2'b00; two_stop = 0; loop = 0; rx_drv = 1;
        step(5);
        tx_wr = 1;
        for (int i = 0; i < 17; i++) begin
            tx_data = 8'(8'h60 + i);
            step(1);
            if (t0 < 0 && tx === 1'b0) t0 = cyc;
        end
        checks++;
        if (tx_full !== 1'b1) begin errors++; $display("FAIL b2b_full: got %b want 1", tx_full); end
        tx_data = 8'hEE;
        step(1);
        tx_wr = 0;
        for (int k = 0; k < 17; k++) begin
            if (k == 0) starts[0] = t0;
            else begin
                n = 0;
                while (tx !== 1'b0 && n < 200) begin
                    step(1);
                    n++;
                end
                starts[k] = cyc;
                checks++;
                if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start%0d: got %b want 0", k, tx); end
            end
            step(starts[k] + 94 - cyc);
            for (int i = 0; i < 8; i++) begin
                if (i > 0) step(64);
                w[i] = tx;
            end
            step(64);
            checks += 2;
            if (tx !== 1'b1) begin errors++; $display("FAIL b2b_stop%0d: got %b want 1", k, tx); end
            if (w !== 8'(8'h60 + k)) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", k, w, 8'(8'h60 + k)); end
            if (k >= 2) begin
                checks++;
                if (starts[k] - starts[k-1] !== 640)
                    begin errors++; $display("FAIL b2b_gap%0d: got %0d want 640", k, starts[k] - starts[k-1]); end
            end
        end
        step(starts[16] + 639 - cyc);
        checks += 2;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_hold: got %b want 1", tx_busy); end
        step(1);
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_fall: got %b want 0", tx_busy); end
        repeat (1000) begin
            step(1);
            if (tx === 1'b0) lows++;
        end
        checks++;
        if (lows !== 0) begin errors++; $display("FAIL b2b_ignored_word: got %0d low cycles want 0", lows); end
    endtask

    task automatic test_mid_reset();
        int s = 0, h = 0;
        dvsr = 651; parity_mode = 2'b00; two_stop = 0; loop = 1;
        write_word(8'hA5);
        write_word(8'h5A);
        while (tx === 1'b0 && s < 20000) begin
            step(1);
            s++;
        end
        while (tx === 1'b1 && h < 20000) begin
            step(1);
            h++;
        end
        checks += 3;
        if (s < 9766 || s > 10416) begin errors++; $display("FAIL 9600_start_len: got %0d want 9766..10416", s); end
        if (h !== 10416) begin errors++; $display("FAIL 9600_bit_len: got %0d want 10416", h); end
        step(100);
        if (tx !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_state: got tx %b busy %b want 0 1", tx, tx_busy); end
        #3 reset_n = 0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx: got %b want 1", tx); end
        step(2);
        reset_n = 1;
        dvsr = 4;
        step(1);
        checks += 3;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", tx_busy); end
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL post_reset_rx_empty: got %b want 1", rx_empty); end
        if (tx_full !== 1'b0) begin errors++; $display("FAIL post_reset_tx_full: got %b want 0", tx_full); end
        step(800);
        checks += 2;
        if (rx_empty !== 1'b1) begin errors++; $display("FAIL partial_rx_discard: got %b want 1", rx_empty); end
        if (tx !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %b want 1", tx); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_glitch();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
